pipe_latch_elastic: RTL and testbench
=====================================

# pipe_latch_elastic

Parametrised elastic pipeline register, replacing fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block. It carries an opaque WIDTH-bit payload between two stages using a valid/ready handshake, with a 2-entry skid buffer and synchronous flush. Stalls propagate one cycle late through a registered `in_ready`, which breaks the combinational stall path through the datapath.

## Interface
- WIDTH, 32, payload bits; the stage's packed struct width.
- CNT_W, 32, performance counter width; used only when PIPE_LATCH_PERF_EN is defined.
- CLK  input  1  clock, rising edge.
- nRST  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  upstream presents a payload.
- in_ready  output  1  block can accept; a registered output.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  `out_data` is meaningful.
- out_ready  input  1  downstream accepts; low means stall.
- out_data  output  WIDTH  head payload; driven directly from the main register.
- occupancy  output  2  entries held (0..2).

## Operation
- Storage is a main register (head) and a skid register. The state is `EMPTY`, `ONE` or `FULL`.
- Outputs are decoded from state:
  - `out_valid` = (state != `EMPTY`).
  - `in_ready` = (state != `FULL`).
  - `occupancy` = 0, 1 or 2 for `EMPTY`, `ONE` and `FULL` respectively.
- Definitions:
  - acc = `in_valid` & `in_ready`.
  - pop = `out_valid` & `out_ready`.
- Transitions when `flush` is low:
  - `EMPTY`: if acc, load main from `in_data` and go to `ONE`.
  - `ONE`, acc & pop: load main from `in_data`, stay in `ONE`.
  - `ONE`, acc & !pop: load skid from `in_data`, go to `FULL`.
  - `ONE`, !acc & pop: go to `EMPTY`. Main keeps its stale value.
  - `ONE`, neither: hold.
  - `FULL`, pop: copy skid to main, go to `ONE`. No accept is possible because `in_ready`=0.
  - `FULL`, !pop: hold.
- `flush` has priority over everything else:
  - Next state is `EMPTY`; main and skid are cleared to 0.
  - An acc or pop in the same cycle is discarded and produces no transfer.
- Payloads leave in arrival order. None is duplicated or lost except by flush.
- `out_data` is undefined-but-stable whenever `out_valid`=0. It equals 0 after reset or flush.

## Timing
- Reset values: state `EMPTY`, `in_ready`=1, `out_valid`=0, `out_data`=0, `occupancy`=0, counters 0.
- Latency: a payload accepted at edge N appears on `out_data` with `out_valid`=1 after edge N.
- Throughput: with `out_ready` held high, one transfer per cycle.
- Stall behaviour: after `out_ready` falls, the block absorbs at most one further payload, then drops `in_ready` at the next edge.
- `in_ready` is a function of state only, never of `out_ready` combinationally.
- Reset asserted mid-operation clears everything asynchronously. The first accept is possible at the first rising edge after release.
- `flush` and `nRST` are independent. Flush never affects counters.

## Configuration
- Macro PIPE_LATCH_PERF_EN.
- Defined: adds two output ports, both saturating at all-ones and cleared only by `nRST`:
  - `stall_cnt` [CNT_W-1:0]: increments each cycle `out_valid` & !`out_ready`.
  - `flush_drop_cnt` [CNT_W-1:0]: increases by `occupancy` on each flush cycle.
- Undefined: both ports and all counter logic are absent. Functional behaviour is identical in both builds.

## Structure
- Package `pipe_latch_pkg` holds:
  - the `latch_state_t` enum (`EMPTY`, `ONE`, `FULL`, 2 bits);
  - the per-stage payload struct typedefs, whose `$bits` give each instance's WIDTH.
- One sub-module, `sat_counter`:
  - parameters W;
  - inputs inc (amount) and en;
  - output count.
- `sat_counter` is instantiated twice under PIPE_LATCH_PERF_EN.

## Test plan
- Reset then pass-through:
  - Stimulus: `in_valid`=1 with `in_data`=0x11,0x22,0x33 on consecutive cycles, `out_ready`=1.
  - Response: the same values appear one cycle later, `occupancy` stays 1, `in_ready` stays 1.
- Downstream stall:
  - Stimulus: drop `out_ready` while streaming 0xA0,0xA1,0xA2.
  - Response: `occupancy` goes 1 then 2; `in_ready` goes 0 the cycle after the second entry is held.
  - On re-raising `out_ready`, output order is 0xA0,0xA1,0xA2 with none lost.
- Flush while FULL with a simultaneous `in_valid`:
  - Response: next cycle `occupancy`=0, `out_valid`=0, `out_data`=0; the incoming payload is dropped.
  - With PERF enabled, `flush_drop_cnt`=2.
- Asynchronous reset mid-stall in FULL:
  - Response: outputs return to reset values immediately, without waiting for a clock edge.
- Random valid/ready:
  - Stimulus: 10k cycles at 50% density each, WIDTH=70.
  - Response: the scoreboard sees in-order, lossless delivery.
  - With PERF enabled, `stall_cnt` equals the count of (`out_valid` & !`out_ready`) cycles.
- Saturation:
  - Stimulus: CNT_W=3, hold a stall for 10 cycles.
  - Response: `stall_cnt` = 7.

Source files
------------

// File: rtl/pipe_latch_pkg.sv
// Shared types for the elastic pipeline register: occupancy state encoding,
// per-stage payload structs (their $bits set each instance's WIDTH), and a
// state-to-occupancy decode helper.
package pipe_latch_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } latch_state_t;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;

    // Per-stage payloads carried across the elastic register.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  rs1_val;
        logic [XLEN-1:0]  rs2_val;
        logic [XLEN-1:0]  imm;
        logic [REG_W-1:0] rd;
        logic [3:0]       alu_op;
    } id_ex_t;

    typedef struct packed {
        logic [XLEN-1:0]  alu_res;
        logic [XLEN-1:0]  store_val;
        logic [REG_W-1:0] rd;
        logic             mem_rd;
        logic             mem_wr;
    } ex_mem_t;

    typedef struct packed {
        logic [XLEN-1:0]  wb_val;
        logic [REG_W-1:0] rd;
        logic             wb_en;
    } mem_wb_t;

    localparam int unsigned IF_ID_W  = $bits(if_id_t);
    localparam int unsigned ID_EX_W  = $bits(id_ex_t);
    localparam int unsigned EX_MEM_W = $bits(ex_mem_t);
    localparam int unsigned MEM_WB_W = $bits(mem_wb_t);

    // Number of held entries for a given state.
    function automatic logic [1:0] state_occupancy(input latch_state_t s);
        case (s)
            EMPTY:   state_occupancy = 2'd0;
            ONE:     state_occupancy = 2'd1;
            FULL:    state_occupancy = 2'd2;
            default: state_occupancy = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_latch_elastic_sat_counter.sv
// Saturating up-counter: adds inc when en is high, sticks at all-ones.
// Ports: CLK, nRST (async active-low), en, inc[W-1:0], count[W-1:0].
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         en,
    input  logic [W-1:0] inc,
    output logic [W-1:0] count
);

    logic [W:0] sum;

    // One extra bit catches the carry that signals saturation.
    assign sum = {1'b0, count} + {1'b0, inc};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else if (en) begin
            count <= sum[W] ? '1 : sum[W-1:0];
        end
    end

endmodule

// File: rtl/pipe_latch_elastic.sv
// Elastic pipeline register: valid/ready handshake with a two-entry skid
// buffer (main = head, skid = overflow) and synchronous flush. in_ready is
// decoded from the state register only, so downstream stalls reach the
// upstream stage one cycle late and never through a combinational path.
// Optional build macro PIPE_LATCH_PERF_EN adds stall_cnt / flush_drop_cnt.
// Ports: CLK, nRST, flush, in_valid/in_ready/in_data (upstream),
//        out_valid/out_ready/out_data (downstream), occupancy (0..2),
//        stall_cnt, flush_drop_cnt (PIPE_LATCH_PERF_EN only).
module pipe_latch_elastic
    import pipe_latch_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
`ifdef PIPE_LATCH_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_drop_cnt
`endif
);

    if (WIDTH < 1 || CNT_W < 1) begin : g_bad_params
        $error("pipe_latch_elastic: WIDTH and CNT_W must be at least 1");
    end

    latch_state_t     state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             acc;
    logic             pop;

    // Handshake outputs depend on registered state only.
    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != FULL);
    assign occupancy = state_occupancy(state_q);
    assign out_data  = main_q;

    assign acc = in_valid & in_ready;
    assign pop = out_valid & out_ready;

    // State and storage registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Next state and storage; flush overrides any transfer in the same cycle.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (acc && pop) begin
                        main_d = in_data;
                    end else if (acc) begin
                        skid_d  = in_data;
                        state_d = FULL;
                    end else if (pop) begin
                        // main keeps its stale value; out_valid masks it
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

`ifdef PIPE_LATCH_PERF_EN
    // Counters ignore flush; only nRST clears them.
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .en    (out_valid & ~out_ready),
        .inc   (CNT_W'(1)),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_drop_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .en    (flush),
        .inc   (CNT_W'(occupancy)),
        .count (flush_drop_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_latch_elastic.sv
// Bench for pipe_latch_elastic: directed scenario tasks plus a negedge
// scoreboard that tracks accepted payloads and checks order, occupancy and
// (with PIPE_LATCH_PERF_EN) the saturating counters.
module tb_pipe_latch_elastic;

    localparam int unsigned WIDTH   = 70;
    localparam int unsigned CNT_W   = 3;
    localparam longint      CNT_MAX = (64'd1 << CNT_W) - 1;

    logic             CLK;
    logic             nRST;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;
`ifdef PIPE_LATCH_PERF_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_drop_cnt;
`endif

    int tests_run = 0;
    int fails     = 0;

    logic [WIDTH-1:0] sb_q[$];
    longint stall_model = 0;
    longint drop_model  = 0;
    longint pops_total  = 0;

    pipe_latch_elastic #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .occupancy      (occupancy)
`ifdef PIPE_LATCH_PERF_EN
        ,
        .stall_cnt      (stall_cnt),
        .flush_drop_cnt (flush_drop_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic longint sat(input longint v);
        sat = (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    // Scoreboard: state is compared first, then the upcoming edge's transfers are applied.
    always @(negedge CLK) begin
        if (!nRST) begin
            sb_q.delete();
            stall_model = 0;
            drop_model  = 0;
        end else begin
            tests_run++;
            if (int'(occupancy) != sb_q.size()) begin
                fails++;
                $display("FAIL sb_occupancy: got %0d expected %0d at %0t", occupancy, sb_q.size(), $time);
            end
            if (out_valid === 1'b1 && sb_q.size() > 0) begin
                tests_run++;
                if (out_data !== sb_q[0]) begin
                    fails++;
                    $display("FAIL sb_order: got %h expected %h at %0t", out_data, sb_q[0], $time);
                end
            end
`ifdef PIPE_LATCH_PERF_EN
            tests_run++;
            if (longint'(stall_cnt) != sat(stall_model)) begin
                fails++;
                $display("FAIL sb_stall_cnt: got %0d expected %0d at %0t", stall_cnt, sat(stall_model), $time);
            end
            tests_run++;
            if (longint'(flush_drop_cnt) != sat(drop_model)) begin
                fails++;
                $display("FAIL sb_flush_drop_cnt: got %0d expected %0d at %0t", flush_drop_cnt, sat(drop_model), $time);
            end
`endif
            if (out_valid === 1'b1 && out_ready === 1'b0) stall_model++;
            if (flush === 1'b1) begin
                drop_model += longint'(sb_q.size());
                sb_q.delete();
            end else begin
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        tests_run++;
                        fails++;
                        $display("FAIL sb_underflow: pop with empty scoreboard at %0t", $time);
                    end else begin
                        void'(sb_q.pop_front());
                        pops_total++;
                    end
                end
                if (in_valid === 1'b1 && in_ready === 1'b1) sb_q.push_back(in_data);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [WIDTH-1:0] d, input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic apply_reset();
        @(posedge CLK);
        #2;
        nRST = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        #3;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || out_data !== '0) begin
            fails++;
            $display("FAIL reset_values: ov=%b ir=%b occ=%0d data=%h expected 0 1 0 0", out_valid, in_ready, occupancy, out_data);
        end
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    task automatic test_pass_through();
        logic [WIDTH-1:0] vals[3];
        vals[0] = 70'h11;
        vals[1] = 70'h22;
        vals[2] = 70'h33;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, vals[i], 1'b1, 1'b0);
            tick();
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== vals[i] || occupancy !== 2'd1 || in_ready !== 1'b1) begin
                fails++;
                $display("FAIL pass_through[%0d]: ov=%b data=%h occ=%0d ir=%b expected 1 %h 1 1", i, out_valid, out_data, occupancy, in_ready, vals[i]);
            end
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            fails++;
            $display("FAIL pass_through_drain: ov=%b occ=%0d expected 0 0", out_valid, occupancy);
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 70'hA0, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (occupancy !== 2'd1 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL stall_first: occ=%0d ir=%b expected 1 1", occupancy, in_ready);
        end
        drive(1'b1, 70'hA1, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 70'hA0) begin
            fails++;
            $display("FAIL stall_full: occ=%0d ir=%b data=%h expected 2 0 a0", occupancy, in_ready, out_data);
        end
        drive(1'b1, 70'hA2, 1'b0, 1'b0);
        tick();
        tests_run++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 70'hA0) begin
            fails++;
            $display("FAIL stall_hold: occ=%0d ir=%b data=%h expected 2 0 a0", occupancy, in_ready, out_data);
        end
        drive(1'b1, 70'hA2, 1'b1, 1'b0);
        tick();
        tests_run++;
        if (occupancy !== 2'd1 || in_ready !== 1'b1 || out_data !== 70'hA1) begin
            fails++;
            $display("FAIL stall_release: occ=%0d ir=%b data=%h expected 1 1 a1", occupancy, in_ready, out_data);
        end
        tick();
        tests_run++;
        if (occupancy !== 2'd1 || out_data !== 70'hA2) begin
            fails++;
            $display("FAIL stall_last: occ=%0d data=%h expected 1 a2", occupancy, out_data);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        tests_run++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL stall_drain: occ=%0d ov=%b expected 0 0", occupancy, out_valid);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        drive(1'b1, 70'hB0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 70'hB1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 70'hB2, 1'b1, 1'b1);
        tick();
        tests_run++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_full: occ=%0d ov=%b data=%h ir=%b expected 0 0 0 1", occupancy, out_valid, out_data, in_ready);
        end
`ifdef PIPE_LATCH_PERF_EN
        tests_run++;
        if (flush_drop_cnt !== 3'd2) begin
            fails++;
            $display("FAIL flush_drop_cnt: got %0d expected 2", flush_drop_cnt);
        end
`endif
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            fails++;
            $display("FAIL flush_no_leak: ov=%b occ=%0d expected 0 0", out_valid, occupancy);
        end
        drive(1'b1, 70'hC0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 70'hC1, 1'b1, 1'b1);
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            fails++;
            $display("FAIL flush_one_acc_pop: ov=%b data=%h expected 0 0", out_valid, out_data);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_async_reset();
        drive(1'b1, 70'hD0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 70'hD1, 1'b0, 1'b0);
        tick();
        #1;
        nRST = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || out_data !== '0) begin
            fails++;
            $display("FAIL async_reset: ov=%b ir=%b occ=%0d data=%h expected 0 1 0 0", out_valid, in_ready, occupancy, out_data);
        end
`ifdef PIPE_LATCH_PERF_EN
        tests_run++;
        if (stall_cnt !== '0 || flush_drop_cnt !== '0) begin
            fails++;
            $display("FAIL async_reset_cnt: stall=%0d drop=%0d expected 0 0", stall_cnt, flush_drop_cnt);
        end
`endif
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        drive(1'b1, 70'hC5, 1'b1, 1'b0);
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 70'hC5 || occupancy !== 2'd1) begin
            fails++;
            $display("FAIL async_first_accept: ov=%b data=%h occ=%0d expected 1 c5 1", out_valid, out_data, occupancy);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_random();
        longint pops_before;
        pops_before = pops_total;
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(1)), {6'($urandom), $urandom, $urandom}, 1'($urandom_range(1)), 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        tests_run++;
        if (sb_q.size() != 0 || occupancy !== 2'd0) begin
            fails++;
            $display("FAIL random_drain: queue=%0d occ=%0d expected 0 0", sb_q.size(), occupancy);
        end
        tests_run++;
        if (pops_total - pops_before < 1000) begin
            fails++;
            $display("FAIL random_throughput: delivered %0d expected at least 1000", pops_total - pops_before);
        end
    endtask

`ifdef PIPE_LATCH_PERF_EN
    task automatic test_saturation();
        apply_reset();
        drive(1'b1, 70'hE0, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        tests_run++;
        if (stall_cnt !== 3'd7) begin
            fails++;
            $display("FAIL stall_saturation: got %0d expected 7", stall_cnt);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_pass_through();
        test_stall();
        test_flush();
        test_async_reset();
        test_random();
`ifdef PIPE_LATCH_PERF_EN
        test_saturation();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
